dmem_responder: RTL and testbench

Multi-cycle data-memory responder: the target end of the pipeline's load/store interface.
- Accepts one request at a time over a valid/ready handshake.
- Holds each request for a programmable number of cycles, then executes the RISC-V funct3-encoded load or store against a word-organised array.
- Returns read data or error status over a valid/ready response channel.
- Replaces the zero-latency data memory when the core is moved to a stall-on-memory pipeline.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_lane_align.sv | 55 +++++
 rtl/dmem_responder.sv | 118 +++++++++++
 tb/tb_dmem_responder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Byte lanes per word; the array is organised as 32-bit words
  localparam int NUM_LANES = 4;

  // Lane mask touched by an access of the given size at the given byte offset
  function automatic logic [NUM_LANES-1:0] byte_en(input logic [2:0] funct3,
                                                   input logic [1:0] addr_lo);
    logic [NUM_LANES-1:0] m;
    case (funct3)
      F3_B, F3_BU: m = 4'b0001 << addr_lo;
      F3_H, F3_HU: m = 4'b0011 << addr_lo;
      F3_W:        m = 4'b1111;
      default:     m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: load extract/extend, store merge, error flag.
// Assumes WIDTH == 8 * NUM_LANES (32-bit words).
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3,
  input  logic [1:0]       addr_lo,
  input  logic [WIDTH-1:0] old_word,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] store_word,
  output logic             err
);

  logic [NUM_LANES-1:0] be;
  logic [WIDTH-1:0]     wdata_sh;
  logic [WIDTH-1:0]     old_sh;

  assign be       = byte_en(funct3, addr_lo);
  assign wdata_sh = wdata << {addr_lo, 3'b000};
  assign old_sh   = old_word >> {addr_lo, 3'b000};

  // Misalignment and illegal-encoding detection
  always_comb begin
    case (funct3)
      F3_B, F3_BU: err = 1'b0;
      F3_H, F3_HU: err = addr_lo[0];
      F3_W:        err = |addr_lo;
      default:     err = 1'b1;
    endcase
  end

  // Load result: addressed lane shifted down, then sign/zero-extended
  always_comb begin
    load_data = '0;
    if (!err) begin
      case (funct3)
        F3_B:    load_data = {{(WIDTH-8){old_sh[7]}}, old_sh[7:0]};
        F3_BU:   load_data = {{(WIDTH-8){1'b0}}, old_sh[7:0]};
        F3_H:    load_data = {{(WIDTH-16){old_sh[15]}}, old_sh[15:0]};
        F3_HU:   load_data = {{(WIDTH-16){1'b0}}, old_sh[15:0]};
        F3_W:    load_data = old_word;
        default: load_data = '0;
      endcase
    end
  end

  // Store merge: enabled lanes take the shifted store data, others keep old bytes
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign store_word[i*8 +: 8] = be[i] ? wdata_sh[i*8 +: 8] : old_word[i*8 +: 8];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding request, fixed latency,
// executes the access at the end of WAIT and holds the response until taken.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 10,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [2:0]       req_funct3,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t           state, state_nxt;
  logic [3:0]       cnt;
  logic             lat_we;
  logic [DEPTH+1:0] lat_addr;
  logic [WIDTH-1:0] lat_wdata;
  logic [2:0]       lat_f3;

  logic [WIDTH-1:0] mem [2**DEPTH];

  logic [DEPTH-1:0] idx;
  logic [WIDTH-1:0] old_word, load_data, store_word;
  logic             acc_err;
  logic             accept, exec;
  logic             unused_addr_hi;

  // Address bits above the array are ignored, so accesses alias
  assign unused_addr_hi = ^req_addr[WIDTH-1:DEPTH+2];

  assign idx      = lat_addr[DEPTH+1:2];
  assign old_word = mem[idx];
  assign accept   = (state == IDLE) && req_valid;
  assign exec     = (state == WAIT) && (cnt == 4'd0);

  dmem_lane_align #(.WIDTH(WIDTH)) u_align (
    .funct3     (lat_f3),
    .addr_lo    (lat_addr[1:0]),
    .old_word   (old_word),
    .wdata      (lat_wdata),
    .load_data  (load_data),
    .store_word (store_word),
    .err        (acc_err)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, latency counter and registered response
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_f3    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr[DEPTH+1:0];
        lat_wdata <= req_wdata;
        lat_f3    <= req_funct3;
        cnt       <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (exec) begin
        rsp_err   <= acc_err;
        rsp_rdata <= lat_we ? '0 : load_data;
      end
    end
  end

  // Array write: commits on the WAIT->RESP edge; reset and errors suppress it
  always_ff @(posedge clk) begin
    if (rst && exec && lat_we && !acc_err) mem[idx] <= store_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY = 2, DEPTH = 10).
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  dmem_responder #(.WIDTH(32), .DEPTH(10), .LATENCY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge; it is accepted on the next rising edge
  task automatic issue(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    chk({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, ".vld_n1"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  // Full transaction with exact latency check and immediate response take
  task automatic transact(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3,
                          input logic [31:0] exp_d, input logic exp_e);
    issue(tag, we, addr, wdata, f3);
    @(negedge clk);
    chk({tag, ".vld_n2"}, {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk({tag, ".vld"},   {31'b0, rsp_valid}, 32'd1);
    chk({tag, ".rdata"}, rsp_rdata, exp_d);
    chk({tag, ".err"},   {31'b0, rsp_err}, {31'b0, exp_e});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".idle_rdy"}, {31'b0, req_ready}, 32'd1);
    chk({tag, ".idle_vld"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_funct3 = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'd0);
    chk("rst.rsp_err",   {31'b0, rsp_err}, 32'd0);
    rst = 1'b1;

    // Word store/load, byte merge, extension
    transact("sw10",   1, 32'h10, 32'hDEADBEEF, 3'd2, 32'h0,        0);
    transact("lw10",   0, 32'h10, 32'h0,        3'd2, 32'hDEADBEEF, 0);
    transact("sb11",   1, 32'h11, 32'h0000007F, 3'd0, 32'h0,        0);
    transact("lw10b",  0, 32'h10, 32'h0,        3'd2, 32'hDEAD7FEF, 0);
    transact("lb13",   0, 32'h13, 32'h0,        3'd0, 32'hFFFFFFDE, 0);
    transact("lbu13",  0, 32'h13, 32'h0,        3'd4, 32'h000000DE, 0);
    transact("lh12",   0, 32'h12, 32'h0,        3'd1, 32'hFFFFDEAD, 0);
    transact("lhu12",  0, 32'h12, 32'h0,        3'd5, 32'h0000DEAD, 0);
    transact("lh11",   0, 32'h11, 32'h0,        3'd1, 32'h0,        1);
    // Errors: misaligned store suppressed, illegal funct3
    transact("sw12",   1, 32'h12, 32'h12345678, 3'd2, 32'h0,        1);
    transact("lw10c",  0, 32'h10, 32'h0,        3'd2, 32'hDEAD7FEF, 0);
    transact("f3_3",   0, 32'h10, 32'h0,        3'd3, 32'h0,        1);
    transact("f3_7",   1, 32'h10, 32'hFFFFFFFF, 3'd7, 32'h0,        1);
    transact("lw10d",  0, 32'h10, 32'h0,        3'd2, 32'hDEAD7FEF, 0);
    // Upper halfword store, positive byte extension
    transact("sw14",   1, 32'h14, 32'h11223344, 3'd2, 32'h0,        0);
    transact("sh16",   1, 32'h16, 32'hCAFEBEEF, 3'd1, 32'h0,        0);
    transact("lw14",   0, 32'h14, 32'h0,        3'd2, 32'hBEEF3344, 0);
    transact("lb14",   0, 32'h14, 32'h0,        3'd0, 32'h00000044, 0);

    // Response backpressure with a competing store held on the request side
    issue("bp", 0, 32'h10, 32'h0, 3'd2);
    @(negedge clk);
    @(negedge clk);
    chk("bp.vld0",   {31'b0, rsp_valid}, 32'd1);
    chk("bp.rdata0", rsp_rdata, 32'hDEAD7FEF);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_funct3 = 3'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.vld",   {31'b0, rsp_valid}, 32'd1);
      chk("bp.rdata", rsp_rdata, 32'hDEAD7FEF);
      chk("bp.err",   {31'b0, rsp_err}, 32'd0);
      chk("bp.rdy",   {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp.rel_rdy", {31'b0, req_ready}, 32'd1);
    chk("bp.rel_vld", {31'b0, rsp_valid}, 32'd0);
    transact("bp.next", 0, 32'h10, 32'h0, 3'd2, 32'hDEAD7FEF, 0);

    // Reset during WAIT discards the pending store (covers the would-be commit edge)
    transact("sw20",   1, 32'h20, 32'h01020304, 3'd2, 32'h0, 0);
    issue("rw", 1, 32'h20, 32'hA5A5A5A5, 3'd2);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("rw.rdy",   {31'b0, req_ready}, 32'd1);
    chk("rw.vld",   {31'b0, rsp_valid}, 32'd0);
    chk("rw.rdata", rsp_rdata, 32'd0);
    chk("rw.err",   {31'b0, rsp_err}, 32'd0);
    transact("lw20",   0, 32'h20,       32'h0, 3'd2, 32'h01020304, 0);
    transact("alias1", 0, 32'h1020,     32'h0, 3'd2, 32'h01020304, 0);
    transact("alias2", 0, 32'h80001020, 32'h0, 3'd2, 32'h01020304, 0);

    // Reset during RESP: response drops, store stays committed
    issue("rr", 1, 32'h24, 32'h0BADF00D, 3'd2);
    @(negedge clk);
    @(negedge clk);
    chk("rr.vld0", {31'b0, rsp_valid}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rr.vld", {31'b0, rsp_valid}, 32'd0);
    chk("rr.rdy", {31'b0, req_ready}, 32'd1);
    transact("lw24", 0, 32'h24, 32'h0, 3'd2, 32'h0BADF00D, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
